lwe_rej_sampler: RTL and testbench
==================================

LWE_REJ_SAMPLER -- requirements
Module: lwe_rej_sampler

Interface
REQ-001: Parameter Q, default 3329, meaning modulus; accepted coefficients lie in [0, Q-1].
REQ-002: Parameter N_COEF, default 256, meaning coefficients produced per start.
REQ-003: Parameter WORD_W, default 256, meaning random-word width from crypto_prng.
REQ-004: Port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005: Port rst, input, 1 bit: synchronous active-high reset.
REQ-006: Port start, input, 1 bit: begin one N_COEF-coefficient run, sampled only in IDLE.
REQ-007: Port rnd_word, input, WORD_W bits: random word from crypto_prng random_word.
REQ-008: Port rnd_valid, input, 1 bit: rnd_word holds fresh data.
REQ-009: Port rnd_ready, output, 1 bit: sampler takes rnd_word this cycle.
REQ-010: Port coef_out, output, 12 bits: sampled coefficient.
REQ-011: Port coef_valid, output, 1 bit: coef_out valid.
REQ-012: Port coef_ready, input, 1 bit: consumer accepts coef_out.
REQ-013: Port busy, output, 1 bit: high in any state other than IDLE.
REQ-014: Port done, output, 1 bit: one-cycle pulse at run end.
REQ-015: Port reject_cnt, output, 16 bits: rejected chunks this run, saturating at 0xFFFF.

Function
REQ-016: A word SHALL split into 21 12-bit chunks; chunk i = rnd_word[12i+11:12i], i=0..20; bits [255:252] discarded.
REQ-017: FSM states SHALL be IDLE, FETCH, SCAN, DRAIN.
REQ-018: IDLE: start=1 -> FETCH next cycle; clear produced counter and reject_cnt; start ignored in other states.
REQ-019: FETCH: rnd_ready=1; rnd_valid=1 -> load word into shift register, chunk index 0, -> SCAN; rnd_ready=0 in all other states.
REQ-020: SCAN: one chunk evaluated per cycle only when output slot free (coef_valid=0 or coef_ready=1); otherwise index and word hold.
REQ-021: Chunk < Q -> accepted: coef_out loaded, coef_valid=1 next cycle, produced counter +1.
REQ-022: Chunk >= Q -> rejected: reject_cnt +1 (saturating), no output.
REQ-023: After evaluating chunk 20 without reaching N_COEF -> FETCH.
REQ-024: Accept making produced = N_COEF -> DRAIN immediately; remaining chunks discarded, no further reject counting.
REQ-025: DRAIN: when coef_valid=0 or coef_ready=1 (last coefficient taken), pulse done for one cycle and -> IDLE.
REQ-026: coef_out and coef_valid SHALL hold stable while coef_valid=1 and coef_ready=0.
REQ-027: Throughput SHALL be one coefficient per cycle with coef_ready held high and all chunks accepted; FETCH costs at least one cycle per word.
REQ-028: Latency start -> first coef_valid SHALL be 3 cycles when rnd_valid=1 and chunk 0 accepted.

Reset
REQ-029: rst=1 SHALL, at the next clock edge, force IDLE, coef_valid=0, coef_out=0, done=0, busy=0, rnd_ready=0, reject_cnt=0, counters=0.
REQ-030: rst mid-run SHALL discard the loaded word and any pending coefficient; no done pulse.
REQ-031: rst SHALL take priority over start.

Structure
REQ-032: Package lwe_pkg SHALL hold Q, CHUNK_W=12, CHUNKS_PER_WORD=21, and the FSM state enum typedef.
REQ-033: Single module; no sub-module; the one-entry output register is internal.

Verification
REQ-034: N_COEF=4, word of all chunks 0x001, coef_ready=1 -> four coef_out=0x001 on consecutive cycles, done pulse, reject_cnt=0, rnd_ready low after first fetch.
REQ-035: First word all chunks 0xFFF, second all 0x005 -> reject_cnt=21, second FETCH, then coefficients 0x005.
REQ-036: Chunk 0=0xD01 (3329), chunk 1=0xD00 (3328) -> chunk 0 rejected, first coef_out=0xD00, reject_cnt=1.
REQ-037: coef_ready low for 5 cycles with coef_valid=1 -> coef_out unchanged, chunk index unchanged, no extra rejects.
REQ-038: rst asserted during SCAN after 2 coefficients -> next cycle IDLE, coef_valid=0, reject_cnt=0, no done; new start runs a full N_COEF.
REQ-039: start pulsed while busy -> ignored; exactly N_COEF coefficients and one done pulse.

Source files
------------

// File: rtl/lwe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lwe_pkg
//  Purpose  : Shared constants and FSM state type for the LWE rejection sampler
//  Revision : 1.0 - initial release
// ============================================================================
package lwe_pkg;

    localparam int Q               = 3329;
    localparam int CHUNK_W         = 12;
    localparam int CHUNKS_PER_WORD = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lwe_rej_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : lwe_rej_sampler
//  Purpose  : Uniform mod-Q coefficient sampler by rejection of 12-bit chunks
//  Revision : 1.0 - initial release
// ============================================================================
module lwe_rej_sampler #(
    parameter int Q      = lwe_pkg::Q,
    parameter int N_COEF = 256,
    parameter int WORD_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] rnd_word,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    output logic [11:0]       coef_out,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       reject_cnt
);
    import lwe_pkg::*;

    localparam int                  c_pcnt_w    = $clog2(N_COEF + 1);
    localparam int                  c_idx_w     = $clog2(CHUNKS_PER_WORD);
    localparam logic [c_pcnt_w-1:0] c_last_coef = c_pcnt_w'(N_COEF - 1);
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(CHUNKS_PER_WORD - 1);
    localparam logic [CHUNK_W:0]    c_q         = (CHUNK_W + 1)'(Q);

    state_t                r_state;
    state_t                w_next_state;
    logic [WORD_W-1:0]     r_word;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_pcnt_w-1:0]   r_produced;
    logic [CHUNK_W-1:0]    r_coef;
    logic                  r_coef_valid;
    logic [15:0]           r_reject;
    logic                  r_done;

    logic                  w_slot_free;
    logic [CHUNK_W-1:0]    w_chunk;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_eval;

    // The current chunk always sits in the low bits; the word shifts down as it is consumed.
    assign w_chunk     = r_word[CHUNK_W-1:0];
    assign w_accept    = {1'b0, w_chunk} < c_q;
    assign w_slot_free = !r_coef_valid || coef_ready;

    assign rnd_ready   = (r_state == FETCH);
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign coef_out    = r_coef;
    assign coef_valid  = r_coef_valid;
    assign reject_cnt  = r_reject;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_eval       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = FETCH;
            end
            FETCH: begin
                if (rnd_valid) begin
                    w_load       = 1'b1;
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (w_slot_free) begin
                    w_eval = 1'b1;
                    if (w_accept && (r_produced == c_last_coef)) w_next_state = DRAIN;
                    else if (r_idx == c_last_idx)                w_next_state = FETCH;
                end
            end
            DRAIN: begin
                if (w_slot_free) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_idx        <= '0;
            r_produced   <= '0;
            r_coef       <= '0;
            r_coef_valid <= 1'b0;
            r_reject     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == DRAIN) && w_slot_free;

            if ((r_state == IDLE) && start) begin
                r_produced <= '0;
                r_reject   <= '0;
            end

            if (w_load) begin
                r_word <= rnd_word;
                r_idx  <= '0;
            end else if (w_eval) begin
                r_word <= r_word >> CHUNK_W;
                r_idx  <= r_idx + 1'b1;
            end

            if (w_eval && w_accept) begin
                r_coef       <= w_chunk;
                r_coef_valid <= 1'b1;
                r_produced   <= r_produced + 1'b1;
            end else if (coef_ready) begin
                r_coef_valid <= 1'b0;
            end

            if (w_eval && !w_accept && (r_reject != 16'hFFFF)) begin
                r_reject <= r_reject + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lwe_rej_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lwe_rej_sampler
//  Purpose  : Randomised self-checking bench for lwe_rej_sampler (N_COEF = 4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lwe_rej_sampler;

    localparam int TB_N = 4;
    localparam int TB_Q = lwe_pkg::Q;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] rnd_word;
    logic         rnd_valid;
    logic         rnd_ready;
    logic [11:0]  coef_out;
    logic         coef_valid;
    logic         coef_ready;
    logic         busy;
    logic         done;
    logic [15:0]  reject_cnt;

    always #5 clk = ~clk;

    lwe_rej_sampler #(.Q(TB_Q), .N_COEF(TB_N), .WORD_W(256)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rnd_word   (rnd_word),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .coef_out   (coef_out),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .busy       (busy),
        .done       (done),
        .reject_cnt (reject_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [255:0] wq[$];       // words still offered to the DUT
    logic [255:0] wlist[$];    // words of the current run, for the model
    logic [11:0]  exp_q[$];
    logic [11:0]  got_q[$];
    int           exp_rej, exp_words;
    int           valid_mode, ready_mode;
    int           cyc, first_valid, last_valid, done_cnt, fetched, rr_cnt;
    logic         hold_prev;
    logic [11:0]  hold_coef;
    logic [15:0]  hold_rej;

    // Reference: walk the words chunk by chunk, keep values below Q until N are found.
    task automatic model();
        int           acc;
        int           cv;
        logic [255:0] t;
        acc = 0;
        exp_q.delete();
        exp_rej   = 0;
        exp_words = 0;
        foreach (wlist[w]) begin
            if (acc == TB_N) break;
            exp_words++;
            for (int i = 0; i < 21; i++) begin
                t  = wlist[w] >> (12 * i);
                cv = int'(t[11:0]);
                if (cv < TB_Q) begin
                    exp_q.push_back(t[11:0]);
                    acc++;
                    if (acc == TB_N) break;
                end else begin
                    exp_rej++;
                end
            end
        end
    endtask

    function automatic logic [255:0] fill(input logic [11:0] c);
        logic [255:0] w;
        w = '1;
        for (int i = 0; i < 21; i++) w[12*i +: 12] = c;
        return w;
    endfunction

    task automatic gen_random(input int rej_heavy);
        logic [255:0] w;
        logic [11:0]  c;
        int           r;
        wlist.delete();
        do begin
            w = '0;
            for (int i = 0; i < 21; i++) begin
                r = int'($urandom_range(0, 9));
                if (rej_heavy != 0)
                    c = (r < 8) ? 12'($urandom_range(TB_Q, 4095)) : 12'($urandom_range(0, TB_Q - 1));
                else if (r == 0) c = 12'(TB_Q - 1);
                else if (r == 1) c = 12'(TB_Q);
                else if (r == 2) c = 12'h000;
                else if (r == 3) c = 12'hFFF;
                else             c = 12'($urandom);
                w[12*i +: 12] = c;
            end
            w[255:252] = 4'($urandom);
            wlist.push_back(w);
            model();
        end while (exp_q.size() < TB_N);
    endtask

    task automatic cycle();
        bit fire;
        fire       = 1'b0;
        rnd_valid  = (wq.size() > 0) && ((valid_mode == 0) || ($urandom_range(0, 2) != 0));
        rnd_word   = (wq.size() > 0) ? wq[0] : '0;
        case (ready_mode)
            0:       coef_ready = 1'b1;
            1:       coef_ready = 1'($urandom_range(0, 1));
            default: coef_ready = !((cyc >= 4) && (cyc < 9));
        endcase
        @(negedge clk);
        if (hold_prev) begin
            check("hold_valid", 32'(coef_valid), 32'd1);
            check("hold_coef", 32'(coef_out), 32'(hold_coef));
            check("hold_rej", 32'(reject_cnt), 32'(hold_rej));
        end
        hold_prev = coef_valid && !coef_ready;
        hold_coef = coef_out;
        hold_rej  = reject_cnt;
        if (coef_valid) begin
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
        end
        if (coef_valid && coef_ready) got_q.push_back(coef_out);
        if (done) done_cnt++;
        if (rnd_ready) rr_cnt++;
        if (rnd_ready && rnd_valid) fire = 1'b1;
        @(posedge clk);
        #1;
        if (fire) begin
            void'(wq.pop_front());
            fetched++;
        end
        cyc++;
    endtask

    task automatic clear_run();
        wq.delete();
        got_q.delete();
        cyc = 0; first_valid = -1; last_valid = -1;
        done_cnt = 0; fetched = 0; rr_cnt = 0; hold_prev = 1'b0;
    endtask

    task automatic run(input int vmode, input int rmode, input int busy_start_at, input string name);
        valid_mode = vmode;
        ready_mode = rmode;
        model();
        clear_run();
        foreach (wlist[i]) wq.push_back(wlist[i]);
        start = 1'b1;
        cycle();
        start = 1'b0;
        while ((done_cnt == 0) && (cyc < 2000)) begin
            if (cyc == busy_start_at) begin
                check({name, "_busy_mid"}, 32'(busy), 32'd1);
                start = 1'b1;
            end
            cycle();
            start = 1'b0;
        end
        if (done_cnt == 0) check({name, "_timeout"}, 32'd0, 32'd1);
        repeat (3) cycle();
        check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_reject"}, 32'(reject_cnt), 32'(exp_rej));
        check({name, "_words"}, 32'(fetched), 32'(exp_words));
        if (vmode == 0) check({name, "_rdy_cycles"}, 32'(rr_cnt), 32'(exp_words));
        check({name, "_ncoef"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_coef%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_word = '0; coef_ready = 1'b0;
        valid_mode = 0; ready_mode = 0;
        clear_run();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(coef_valid), 32'd0);
        check("rst_coef", 32'(coef_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdy", 32'(rnd_ready), 32'd0);
        check("rst_rej", 32'(reject_cnt), 32'd0);
        rst = 1'b0;

        // All-accept word: latency and back-to-back throughput
        wlist.delete();
        wlist.push_back(fill(12'h001));
        run(0, 0, -1, "ones");
        check("ones_latency", 32'(first_valid), 32'd3);
        check("ones_span", 32'(last_valid - first_valid), 32'(TB_N - 1));

        // Fully rejected word followed by an accepting one
        wlist.delete();
        wlist.push_back(fill(12'hFFF));
        wlist.push_back(fill(12'h005));
        run(1, 0, -1, "rej21");

        // Boundary: Q rejected, Q-1 accepted
        wlist.delete();
        wlist.push_back(fill(12'h123));
        wlist[0][11:0]  = 12'hD01;
        wlist[0][23:12] = 12'hD00;
        run(0, 0, -1, "bound");

        // Consumer stalls for five cycles while a coefficient is pending
        gen_random(0);
        run(0, 2, -1, "stall");

        // Reset in the middle of a run, with start asserted alongside it
        valid_mode = 0;
        ready_mode = 0;
        clear_run();
        wlist.delete();
        wlist.push_back('1);
        for (int i = 0; i < 21; i += 2) wlist[0][12*i +: 12] = 12'hFFF;
        for (int i = 1; i < 21; i += 2) wlist[0][12*i +: 12] = 12'h001;
        wq.push_back(wlist[0]);
        start = 1'b1;
        cycle();
        start = 1'b0;
        while ((got_q.size() < 2) && (cyc < 100)) cycle();
        check("mid_rst_reached", 32'(got_q.size()), 32'd2);
        check("mid_rst_prerej", 32'(reject_cnt != 16'd0), 32'd1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        check("mid_rst_valid", 32'(coef_valid), 32'd0);
        check("mid_rst_rej", 32'(reject_cnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rdy", 32'(rnd_ready), 32'd0);
        clear_run();
        repeat (3) cycle();
        check("mid_rst_nodone", 32'(done_cnt), 32'd0);
        gen_random(0);
        run(0, 1, -1, "after_rst");

        // Start pulse while busy must be ignored
        gen_random(1);
        run(0, 1, 4, "busy_start");

        for (int k = 0; k < 20; k++) begin
            gen_random(int'($urandom_range(0, 1)));
            run(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
